// File: rtl/tt_tbuf_bus_arb.sv
// Round-robin enable sequencer for N_REQ tristate drivers sharing one net.
// At most one TE_B is low, with a dead time between owners so drivers never fight.
module tt_tbuf_bus_arb #(
  parameter int N_REQ       = 4,
  parameter int DEAD_CYCLES = 2,
  parameter int MAX_HOLD    = 0,
  parameter int HOLD_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     force_off,
  output logic [N_REQ-1:0]         tbuf_tx,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     bus_busy,
  output logic                     preempt
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int D    = (DEAD_CYCLES < 1) ? 1 : DEAD_CYCLES;
  localparam int TC_W = (D < 2) ? 1 : $clog2(D);
  localparam logic [TC_W-1:0]  TC_LAST = TC_W'(D - 1);
  localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_TURN} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  tbuf_tx_q, tbuf_tx_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic              busy_q, busy_d;
  logic              preempt_q, preempt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TC_W-1:0]   tcnt_q, tcnt_d;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_id;
  logic              others_waiting;
  logic              hold_reached;
  logic              release_c;
  logic              limit_c;

  // First set request scanning upward from last+1 with wrap; the index is kept
  // one bit wider so the wrap also works when N_REQ is not a power of two.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [ID_W-1:0]  last);
    logic [ID_W:0]   idx;
    logic            found;
    logic [ID_W-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = {1'b0, last} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (!found && r[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
    return {found, win};
  endfunction

  assign {pick_valid, pick_id} = rr_pick(req, last_q);
  assign others_waiting = |(req & ~(ONE << owner_q));

  // Once the hold limit has been reached the owner yields as soon as anyone else asks.
  if (MAX_HOLD == 0) begin : g_no_limit
    assign hold_reached = 1'b0;
  end else if (MAX_HOLD == 1) begin : g_limit_one
    assign hold_reached = 1'b1;
  end else begin : g_limit
    assign hold_reached = (hold_q >= HOLD_W'(MAX_HOLD - 1));
  end

  assign release_c = !req[owner_q] || force_off;
  assign limit_c   = hold_reached && others_waiting;

  always_comb begin
    state_d   = state_q;
    tbuf_tx_d = tbuf_tx_q;
    owner_d   = owner_q;
    last_d    = last_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
    hold_d    = hold_q;
    tcnt_d    = tcnt_q;
    case (state_q)
      ST_DRIVE: begin
        hold_d = (&hold_q) ? hold_q : hold_q + 1'b1;
        if (release_c || limit_c) begin
          state_d   = ST_TURN;
          tbuf_tx_d = '1;
          busy_d    = 1'b0;
          tcnt_d    = '0;
          preempt_d = !release_c;
        end
      end
      ST_TURN: begin
        if (tcnt_q != TC_LAST) begin
          tcnt_d = tcnt_q + 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
    // Arbitration point: idle, or the final dead-time cycle.
    if ((state_q == ST_IDLE || (state_q == ST_TURN && tcnt_q == TC_LAST)) &&
        pick_valid && !force_off) begin
      state_d   = ST_DRIVE;
      tbuf_tx_d = ~(ONE << pick_id);
      owner_d   = pick_id;
      last_d    = pick_id;
      busy_d    = 1'b1;
      hold_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tbuf_tx_q <= '1;
      owner_q   <= '0;
      last_q    <= ID_W'(N_REQ - 1);
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      hold_q    <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      tbuf_tx_q <= tbuf_tx_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign tbuf_tx  = tbuf_tx_q;
  assign grant    = ~tbuf_tx_q;
  assign owner_id = owner_q;
  assign bus_busy = busy_q;
  assign preempt  = preempt_q;

  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~tbuf_tx_q));

endmodule

// File: tb/tb_tt_tbuf_bus_arb.sv
// Bench for tt_tbuf_bus_arb: directed scenarios plus random req/force_off on two
// configurations, every cycle compared against a rule-level ownership model.
module tb_tt_tbuf_bus_arb;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       force_off = 1'b0;
  logic [3:0] req0 = '0;
  logic [2:0] req1 = '0;
  logic [3:0] tbuf_tx0, grant0;
  logic [1:0] owner_id0;
  logic       bus_busy0, preempt0;
  logic [2:0] tbuf_tx1, grant1;
  logic [1:0] owner_id1;
  logic       bus_busy1, preempt1;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // u0: 4 drivers, 2 dead cycles, 4-cycle hold limit
  tt_tbuf_bus_arb #(.N_REQ(4), .DEAD_CYCLES(2), .MAX_HOLD(4), .HOLD_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .force_off(force_off),
    .tbuf_tx(tbuf_tx0), .grant(grant0), .owner_id(owner_id0),
    .bus_busy(bus_busy0), .preempt(preempt0));

  // u1: 3 drivers, dead time 0 (acts as 1), unlimited hold
  tt_tbuf_bus_arb #(.N_REQ(3), .DEAD_CYCLES(0), .MAX_HOLD(0), .HOLD_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .force_off(force_off),
    .tbuf_tx(tbuf_tx1), .grant(grant1), .owner_id(owner_id1),
    .bus_busy(bus_busy1), .preempt(preempt1));

  // Reference: who owns the bus, how long they have had it, dead-time progress.
  typedef struct {
    int owner;   // -1 when no driver is enabled
    int last;
    int hold;    // drive cycles already completed beyond the first
    int gap;     // dead-time cycles elapsed
    bit turn;
    bit pre;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_reset(int n);
    mdl_t s;
    s.owner = -1; s.last = n - 1; s.hold = 0; s.gap = 0; s.turn = 0; s.pre = 0;
    return s;
  endfunction

  function automatic int rr_winner(int n, int last, logic [15:0] r);
    for (int k = 1; k <= n; k++) begin
      if (r[(last + k) % n]) return (last + k) % n;
    end
    return -1;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, int n, int d, int maxh,
                                    logic [15:0] r, bit fo);
    mdl_t t;
    bit   others;
    bit   may_pick;
    int   w;
    t = s;
    t.pre = 0;
    others = 0;
    may_pick = 1;
    if (s.owner >= 0) begin
      for (int i = 0; i < n; i++) if (i != s.owner && r[i]) others = 1;
      if (!r[s.owner] || fo) begin
        t.owner = -1; t.turn = 1; t.gap = 0;
      end else if (maxh > 0 && s.hold + 1 >= maxh && others) begin
        t.owner = -1; t.turn = 1; t.gap = 0; t.pre = 1;
      end else begin
        t.hold = s.hold + 1;
      end
    end else begin
      if (s.turn) begin
        t.gap = s.gap + 1;
        may_pick = (t.gap >= d);
      end
      if (may_pick) begin
        t.turn = 0;
        w = fo ? -1 : rr_winner(n, s.last, r);
        if (w >= 0) begin
          t.owner = w; t.last = w; t.hold = 0;
        end
      end
    end
    return t;
  endfunction

  function automatic logic [15:0] exp_tx(mdl_t s, int n);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = (i != s.owner);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  bit log_on = 1;
  bit starve_on = 0;
  bit prev0 = 0, had0 = 0, prev1 = 0, had1 = 0;
  int off0 = 0, off1 = 0;
  int wait0 [4];

  task automatic check_all();
    logic [15:0] e;
    logic [3:0]  etx0, egr0;
    logic [2:0]  etx1, egr1;
    e = exp_tx(m0, 4);
    etx0 = e[3:0];
    egr0 = ~etx0;
    e = exp_tx(m1, 3);
    etx1 = e[2:0];
    egr1 = ~etx1;
    chk("u0_tx", 32'(tbuf_tx0), 32'(etx0));
    chk("u0_grant", 32'(grant0), 32'(egr0));
    chk("u0_busy", 32'(bus_busy0), 32'(m0.owner >= 0));
    chk("u0_preempt", 32'(preempt0), 32'(m0.pre));
    chk("u0_onehot0", 32'($onehot0(~tbuf_tx0)), 32'd1);
    if (m0.owner >= 0) chk("u0_owner", 32'(owner_id0), 32'(m0.owner));
    chk("u1_tx", 32'(tbuf_tx1), 32'(etx1));
    chk("u1_grant", 32'(grant1), 32'(egr1));
    chk("u1_busy", 32'(bus_busy1), 32'(m1.owner >= 0));
    chk("u1_preempt", 32'(preempt1), 32'(m1.pre));
    chk("u1_onehot0", 32'($onehot0(~tbuf_tx1)), 32'd1);
    if (m1.owner >= 0) chk("u1_owner", 32'(owner_id1), 32'(m1.owner));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m0 = mdl_reset(4);
      m1 = mdl_reset(3);
    end else begin
      m0 = mdl_step(m0, 4, 2, 4, 16'(req0), force_off);
      m1 = mdl_step(m1, 3, 1, 0, 16'(req1), force_off);
    end
    #1;
    cyc++;
    check_all();
    if (!rst_n) begin
      had0 = 0; had1 = 0; prev0 = 0; prev1 = 0; off0 = 0; off1 = 0;
    end else begin
      if (bus_busy0) begin
        if (!prev0 && had0) chk("u0_gap", 32'(off0 >= 2), 32'd1);
        if (!prev0 && log_on) $display("u0 grant owner=%0d cycle=%0d", owner_id0, cyc);
        had0 = 1; off0 = 0;
      end else off0++;
      if (bus_busy1) begin
        if (!prev1 && had1) chk("u1_gap", 32'(off1 >= 1), 32'd1);
        if (!prev1 && log_on) $display("u1 grant owner=%0d cycle=%0d", owner_id1, cyc);
        had1 = 1; off1 = 0;
      end else off1++;
      prev0 = bus_busy0;
      prev1 = bus_busy1;
    end
    for (int i = 0; i < 4; i++) begin
      if (req0[i] && !grant0[i]) wait0[i]++;
      else wait0[i] = 0;
      if (starve_on) chk("u0_starve", 32'(wait0[i] > 4 * (4 + 2)), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_owner_id", 32'(owner_id0), 32'd0);
    chk("rst_tx", 32'(tbuf_tx0), 32'hF);
    rst_n = 1'b1;
  endtask

  initial begin
    int owners[$];
    int busy_ticks;
    int pre_cnt;
    bit pb;
    m0 = mdl_reset(4);
    m1 = mdl_reset(3);
    for (int i = 0; i < 4; i++) wait0[i] = 0;
    do_reset();

    // Two requesters, owner releases, dead time, then the other wins.
    req0 = 4'b0101;
    tick();
    chk("t1_grant", 32'(grant0), 32'h1);
    chk("t1_tx", 32'(tbuf_tx0), 32'hE);
    req0 = 4'b0100;
    tick();
    chk("t1_off_a", 32'(tbuf_tx0), 32'hF);
    tick();
    chk("t1_off_b", 32'(tbuf_tx0), 32'hF);
    tick();
    chk("t1_next", 32'(grant0), 32'h4);

    // Reset mid-drive: enables drop at once, priority restarts at req[0].
    req0 = 4'b0111;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_async_tx", 32'(tbuf_tx0), 32'hF);
    chk("t5_async_busy", 32'(bus_busy0), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_rr", 32'(grant0), 32'h1);
    req0 = 4'b0000;
    repeat (4) tick();

    // All requesting with a 4-cycle hold limit: strict rotation with preemption.
    do_reset();
    req0 = 4'b1111;
    busy_ticks = 0;
    pre_cnt = 0;
    pb = 0;
    for (int t = 0; t < 26; t++) begin
      tick();
      if (bus_busy0 && !pb) owners.push_back(int'(owner_id0));
      if (bus_busy0) busy_ticks++;
      if (preempt0) pre_cnt++;
      pb = bus_busy0;
    end
    chk("t2_n_owners", 32'(owners.size()), 32'd5);
    for (int i = 0; i < owners.size() && i < 5; i++)
      chk("t2_owner_seq", 32'(owners[i]), 32'(i % 4));
    chk("t2_busy_ticks", 32'(busy_ticks), 32'd18);
    chk("t2_preempts", 32'(pre_cnt), 32'd4);
    req0 = 4'b0000;

    // force_off mid-drive releases next edge and blocks grants until cleared.
    do_reset();
    req0 = 4'b0011;
    tick();
    chk("t4_first", 32'(grant0), 32'h1);
    tick();
    force_off = 1'b1;
    tick();
    chk("t4_off", 32'(tbuf_tx0), 32'hF);
    repeat (5) begin
      tick();
      chk("t4_blocked", 32'(grant0), 32'h0);
    end
    force_off = 1'b0;
    tick();
    chk("t4_resume", 32'(grant0), 32'h2);
    req0 = 4'b0000;

    // Zero dead time on u1: a lone requester toggling sees exactly one off cycle.
    for (int r = 0; r < 4; r++) begin
      req1 = 3'b001;
      repeat (3) tick();
      req1 = 3'b000;
      tick();
      chk("t3_off", 32'(bus_busy1), 32'd0);
      req1 = 3'b001;
      tick();
      chk("t3_regrant", 32'(grant1), 32'h1);
    end
    req1 = 3'b000;
    repeat (4) tick();

    // Random traffic without force_off: starvation bound is checked here.
    log_on = 0;
    for (int i = 0; i < 4; i++) wait0[i] = 0;
    starve_on = 1;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) req0[i] = ~req0[i];
      for (int i = 0; i < 3; i++) if ($urandom_range(7) == 0) req1[i] = ~req1[i];
      tick();
    end
    starve_on = 0;

    // Random traffic with force_off pulses and occasional resets.
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) req0[i] = ~req0[i];
      for (int i = 0; i < 3; i++) if ($urandom_range(7) == 0) req1[i] = ~req1[i];
      if ($urandom_range(15) == 0) force_off = ~force_off;
      if ($urandom_range(599) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
